// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port arbiter between instruction fetch, load and store
// requesters onto one downstream memory channel.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard (promotes ic after STARVE_LIMIT lost decisions).
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        dn_valid,
  output logic        dn_wr,
  output logic [31:0] dn_addr,
  output logic [2:0]  dn_size,
  output logic [31:0] dn_wdata,
  input  logic [31:0] dn_rdata,
  input  logic        dn_done
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_LD, OWN_ST} owner_t;

  state_t state, state_nx;
  owner_t owner, owner_nx;
  logic   grant_ic, grant_ld, grant_st;
  logic   cancel, finish;
  logic   ic_ok, ld_ok, promote;

  // clr blocks new fetch/load grants; stores are never affected by a flush
  assign ic_ok = ic_req && !clr;
  assign ld_ok = ld_req && !clr;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  assign promote = ic_ok && (starve_cnt >= 4'(STARVE_LIMIT));

  // Count IDLE decisions that fetch lost; any fetch grant, idle fetch or flush clears it
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (rdy && state == IDLE) begin
      if (clr || !ic_req || grant_ic)
        starve_cnt <= '0;
      else if (starve_cnt != 4'hF)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign promote = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end

  // Next-state, arbitration and transaction-end decode; everything frozen when rdy is low
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    grant_ic = 1'b0;
    grant_ld = 1'b0;
    grant_st = 1'b0;
    cancel   = 1'b0;
    finish   = 1'b0;
    if (rdy) begin
      case (state)
        IDLE: begin
          grant_ic = promote || (ic_ok && !st_req && !ld_ok);
          grant_st = st_req && !promote;
          grant_ld = ld_ok && !st_req && !promote;
          if (grant_st) begin
            state_nx = BUSY;
            owner_nx = OWN_ST;
          end else if (grant_ld) begin
            state_nx = BUSY;
            owner_nx = OWN_LD;
          end else if (grant_ic) begin
            state_nx = BUSY;
            owner_nx = OWN_IC;
          end
        end
        BUSY: begin
          // a flush beats a simultaneous dn_done for fetch/load owners
          if (clr && owner != OWN_ST) begin
            cancel   = 1'b1;
            state_nx = RESP;
            owner_nx = OWN_NONE;
          end else if (dn_done) begin
            finish   = 1'b1;
            state_nx = RESP;
            owner_nx = OWN_NONE;
          end
        end
        RESP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Registered downstream request, done pulses and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_wr    <= 1'b0;
      dn_addr  <= '0;
      dn_size  <= '0;
      dn_wdata <= '0;
      ic_done  <= 1'b0;
      ld_done  <= 1'b0;
      st_done  <= 1'b0;
      ic_data  <= '0;
      ld_data  <= '0;
    end else begin
      ic_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;
      if (grant_st) begin
        dn_valid <= 1'b1;
        dn_wr    <= 1'b1;
        dn_addr  <= st_addr;
        dn_size  <= st_size;
        dn_wdata <= st_data;
      end else if (grant_ld) begin
        dn_valid <= 1'b1;
        dn_wr    <= 1'b0;
        dn_addr  <= ld_addr;
        dn_size  <= ld_size;
      end else if (grant_ic) begin
        dn_valid <= 1'b1;
        dn_wr    <= 1'b0;
        dn_addr  <= ic_addr;
        dn_size  <= 3'd4;
      end
      if (cancel)
        dn_valid <= 1'b0;
      if (finish) begin
        dn_valid <= 1'b0;
        case (owner)
          OWN_IC: begin
            ic_done <= 1'b1;
            ic_data <= dn_rdata;
          end
          OWN_LD: begin
            ld_done <= 1'b1;
            ld_data <= dn_rdata;
          end
          OWN_ST:  st_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  logic        clk, rst, rdy, clr;
  logic        ic_req, ic_done;
  logic [31:0] ic_addr, ic_data;
  logic        ld_req, ld_done;
  logic [31:0] ld_addr, ld_data;
  logic [2:0]  ld_size;
  logic        st_req, st_done;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_size;
  logic        dn_valid, dn_wr, dn_done;
  logic [31:0] dn_addr, dn_wdata, dn_rdata;
  logic [2:0]  dn_size;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data), .st_done(st_done),
    .dn_valid(dn_valid), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_size(dn_size),
    .dn_wdata(dn_wdata), .dn_rdata(dn_rdata), .dn_done(dn_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_valid"}, {31'd0, dn_valid}, 32'd0);
    chk({tag, "_dones"}, {29'd0, ic_done, ld_done, st_done}, 32'd0);
  endtask

  initial begin
    rst = 1; rdy = 1; clr = 0;
    ic_req = 0; ic_addr = 0;
    ld_req = 0; ld_addr = 0; ld_size = 0;
    st_req = 0; st_addr = 0; st_size = 0; st_data = 0;
    dn_rdata = 0; dn_done = 0;
    tick(2);
    chk_idle_outs("rst");
    chk("rst_wr",    {31'd0, dn_wr}, 32'd0);
    chk("rst_addr",  dn_addr, 32'd0);
    chk("rst_size",  {29'd0, dn_size}, 32'd0);
    chk("rst_wdata", dn_wdata, 32'd0);
    chk("rst_icdat", ic_data, 32'd0);
    chk("rst_lddat", ld_data, 32'd0);
    rst = 0;
    tick();
    chk_idle_outs("post_rst");

    // single fetch, 5-cycle downstream latency
    ic_req = 1; ic_addr = 32'h1000;
    tick();
    chk("ic_valid", {31'd0, dn_valid}, 32'd1);
    chk("ic_addr",  dn_addr, 32'h1000);
    chk("ic_size",  {29'd0, dn_size}, 32'd4);
    chk("ic_wr",    {31'd0, dn_wr}, 32'd0);
    tick(4);
    chk("ic_hold_valid", {31'd0, dn_valid}, 32'd1);
    chk("ic_hold_done",  {31'd0, ic_done}, 32'd0);
    dn_done = 1; dn_rdata = 32'h00A00093;
    tick();
    dn_done = 0; ic_addr = 32'h1004;   // new fetch held immediately
    chk("ic_done",  {31'd0, ic_done}, 32'd1);
    chk("ic_data",  ic_data, 32'h00A00093);
    chk("ic_dv_lo", {31'd0, dn_valid}, 32'd0);
    tick();
    chk("ic_done_1cyc", {31'd0, ic_done}, 32'd0);
    chk("ic_gap2",      {31'd0, dn_valid}, 32'd0);
    tick();
    chk("ic_regrant", {31'd0, dn_valid}, 32'd1);
    chk("ic_addr2",   dn_addr, 32'h1004);
    dn_done = 1; dn_rdata = 32'h1;
    tick();
    dn_done = 0; ic_req = 0;
    chk("ic_done2", {31'd0, ic_done}, 32'd1);
    tick();

    // priority st > ld > ic
    st_req = 1; st_addr = 32'h2000; st_size = 4; st_data = 32'hDEADBEEF;
    ld_req = 1; ld_addr = 32'h3000; ld_size = 2;
    ic_req = 1; ic_addr = 32'h1000;
    tick();
    chk("pri_st_addr",  dn_addr, 32'h2000);
    chk("pri_st_wr",    {31'd0, dn_wr}, 32'd1);
    chk("pri_st_wdata", dn_wdata, 32'hDEADBEEF);
    dn_done = 1;
    tick();
    dn_done = 0; st_req = 0;
    chk("pri_st_done", {29'd0, ic_done, ld_done, st_done}, 32'b001);
    tick(2);
    chk("pri_ld_addr", dn_addr, 32'h3000);
    chk("pri_ld_wr",   {31'd0, dn_wr}, 32'd0);
    chk("pri_ld_size", {29'd0, dn_size}, 32'd2);
    dn_done = 1; dn_rdata = 32'h11223344;
    tick();
    dn_done = 0; ld_req = 0;
    chk("pri_ld_done", {29'd0, ic_done, ld_done, st_done}, 32'b010);
    chk("pri_ld_data", ld_data, 32'h11223344);
    tick(2);
    chk("pri_ic_addr", dn_addr, 32'h1000);
    chk("pri_ic_wr",   {31'd0, dn_wr}, 32'd0);
    dn_done = 1; dn_rdata = 32'h55;
    tick();
    dn_done = 0; ic_req = 0;
    chk("pri_ic_done", {29'd0, ic_done, ld_done, st_done}, 32'b100);
    tick();

    // clr together with dn_done cancels an owned load
    ld_req = 1; ld_addr = 32'h4000; ld_size = 1;
    tick();
    chk("clr_ld_valid", {31'd0, dn_valid}, 32'd1);
    clr = 1; dn_done = 1; dn_rdata = 32'hBAD;
    tick();
    clr = 0; dn_done = 0;
    chk("clr_ld_nodone", {31'd0, ld_done}, 32'd0);
    chk("clr_ld_dv",     {31'd0, dn_valid}, 32'd0);
    chk("clr_ld_data",   ld_data, 32'h11223344);
    tick();
    chk("clr_resp_dv", {31'd0, dn_valid}, 32'd0);
    tick();
    chk("clr_regrant", {31'd0, dn_valid}, 32'd1);
    dn_done = 1; dn_rdata = 32'h77;
    tick();
    dn_done = 0; ld_req = 0;
    chk("clr_ld_done2", {31'd0, ld_done}, 32'd1);
    tick();

    // clr leaves an owned store alone
    st_req = 1;
    tick();
    chk("clr_st_valid", {31'd0, dn_valid}, 32'd1);
    clr = 1;
    tick();
    clr = 0;
    chk("clr_st_dv",    {31'd0, dn_valid}, 32'd1);
    chk("clr_st_wdata", dn_wdata, 32'hDEADBEEF);
    dn_done = 1;
    tick();
    dn_done = 0; st_req = 0;
    chk("clr_st_done",  {31'd0, st_done}, 32'd1);
    chk("clr_st_wd2",   dn_wdata, 32'hDEADBEEF);
    tick();

    // starvation: ld held high while ic waits
    ic_req = 1; ic_addr = 32'h1000;
    ld_req = 1; ld_addr = 32'h3000; ld_size = 4;
    tick();
    for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk("starve_addr", dn_addr, (k == 2) ? 32'h1000 : 32'h3000);
`else
      chk("starve_addr", dn_addr, 32'h3000);
`endif
      dn_done = 1;
      tick();
      dn_done = 0;
      tick(2);
    end
    ic_req = 0; ld_req = 0;
    dn_done = 1;
    tick();
    dn_done = 0;
    tick(2);
    chk_idle_outs("starve_end");

    // rdy low mid-BUSY swallows dn_done
    ld_req = 1; ld_addr = 32'h5000; ld_size = 4;
    tick();
    chk("rdy_valid", {31'd0, dn_valid}, 32'd1);
    rdy = 0;
    for (int k = 0; k < 3; k++) begin
      dn_done = (k == 1); dn_rdata = 32'hCAFE0000;
      tick();
      chk("rdy_nodone", {31'd0, ld_done}, 32'd0);
      chk("rdy_dv",     {31'd0, dn_valid}, 32'd1);
      chk("rdy_addr",   dn_addr, 32'h5000);
    end
    dn_done = 0; rdy = 1;
    tick();
    chk("rdy_still_busy", {31'd0, dn_valid}, 32'd1);
    chk("rdy_nodone2",    {31'd0, ld_done}, 32'd0);
    dn_done = 1; dn_rdata = 32'h0BADF00D;
    tick();
    dn_done = 0; ld_req = 0;
    chk("rdy_ld_done", {31'd0, ld_done}, 32'd1);
    chk("rdy_ld_data", ld_data, 32'h0BADF00D);

    // rst mid-BUSY wins over rdy low and clr
    st_req = 1;
    tick(2);
    chk("rst_busy_dv", {31'd0, dn_valid}, 32'd1);
    rst = 1; rdy = 0; clr = 1;
    tick();
    chk_idle_outs("rst_mid");
    chk("rst_mid_wr",    {31'd0, dn_wr}, 32'd0);
    chk("rst_mid_addr",  dn_addr, 32'd0);
    chk("rst_mid_wdata", dn_wdata, 32'd0);
    chk("rst_mid_size",  {29'd0, dn_size}, 32'd0);
    chk("rst_mid_lddat", ld_data, 32'd0);
    chk("rst_mid_icdat", ic_data, 32'd0);
    st_req = 0; rst = 0; rdy = 1; clr = 0;
    tick();
    chk_idle_outs("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive lost IDLE grant decisions before instruction fetch is promoted (range 1..15).
REQ-002 The block SHALL have a single clock `clk`, and reset `rst` SHALL be synchronous and active-high.
REQ-003 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes the block
- clr  in  1  pipeline flush; cancels fetch/load
- ic_req  in  1  fetch request, held until ic_done
- ic_addr  in  32  fetch address
- ic_done  out  1  one-cycle fetch completion
- ic_data  out  32  fetched word, valid with ic_done
- ld_req  in  1  load request, held until ld_done
- ld_addr  in  32  load address
- ld_size  in  3  load bytes (1, 2 or 4)
- ld_done  out  1  one-cycle load completion
- ld_data  out  32  load data, valid with ld_done
- st_req  in  1  store request, held until st_done
- st_addr  in  32  store address
- st_size  in  3  store bytes (1, 2 or 4)
- st_data  in  32  store data
- st_done  out  1  one-cycle store completion
- dn_valid  out  1  request to memory controller, held until dn_done
- dn_wr  out  1  1 = store
- dn_addr  out  32  downstream address
- dn_size  out  3  downstream byte count
- dn_wdata  out  32  downstream store data
- dn_rdata  in  32  downstream read data, valid with dn_done
- dn_done  in  1  one-cycle downstream completion

Function
REQ-004 The FSM SHALL have three states: IDLE (arbitrate), BUSY (owner granted, dn_valid high), RESP (one-cycle gap after completion or cancel).
REQ-005 In IDLE with rdy high, the block SHALL grant by priority st > ld > ic. All dn_* outputs and dn_valid SHALL be registered and appear one cycle after the grant decision.
REQ-006 On a grant, the block SHALL latch the owner and operands. For ic, dn_size SHALL be 4 and dn_wr SHALL be 0. For ld, dn_wr SHALL be 0. For st, dn_wr SHALL be 1. Operands SHALL stay constant through BUSY.
REQ-007 In BUSY, when dn_done is sampled high, then at the next edge:
- the owner's done SHALL be high for exactly one cycle;
- for ic/ld, the data output SHALL be dn_rdata captured at that edge;
- dn_valid SHALL be 0;
- the state SHALL be RESP.
REQ-008 RESP SHALL last exactly one cycle with no grant and SHALL then return to IDLE. Back-to-back transactions are therefore separated by at least two cycles of dn_valid low.
REQ-009 Requests arriving while BUSY or RESP SHALL be held by requesters and SHALL NOT be lost. The block SHALL NOT re-grant a requester in the cycle it receives done.
REQ-010 clr in IDLE SHALL suppress ic/ld grants in that cycle; st_req SHALL still be granted.
REQ-011 clr in BUSY with owner ic or ld SHALL deassert dn_valid at the next edge and enter RESP with no done pulse. A dn_done in the same cycle SHALL be discarded.
REQ-012 clr SHALL NOT affect an owned store; the store SHALL complete with st_done.
REQ-013 rdy low SHALL hold all state, counters and dn_* outputs. Done outputs SHALL be 0. A dn_done sampled while rdy is low SHALL be ignored.
REQ-014 At most one of ic_done, ld_done, st_done SHALL be high in any cycle.

Reset
REQ-015 rst SHALL force:
- state IDLE and owner none;
- dn_valid, dn_wr, ic_done, ld_done, st_done to 0;
- dn_addr, dn_size, dn_wdata, ic_data, ld_data to 0;
- the starvation counter to 0.
REQ-016 rst SHALL take effect mid-transaction, and SHALL take precedence over rdy and clr.

Configuration
REQ-017 With MEM_ARB_STARVE_GUARD_EN defined, a 4-bit counter SHALL increment on each IDLE decision where ic_req is high but not granted, and SHALL clear on an ic grant, when ic_req is low, or on clr.
REQ-018 With MEM_ARB_STARVE_GUARD_EN defined, when the counter reaches STARVE_LIMIT, ic SHALL win the next IDLE decision over ld and st (unless clr is high).
REQ-019 Without MEM_ARB_STARVE_GUARD_EN, no counter SHALL exist and priority SHALL be strictly st > ld > ic.

Verification
REQ-020 The bench SHALL cover each of the following scenarios:
- ic_req, ic_addr=0x1000; dn_done after 5 cycles with dn_rdata=0x00A00093 -> dn_valid/dn_addr=0x1000 one cycle after request; ic_done=1 with ic_data=0x00A00093 for one cycle; next dn_valid no earlier than 2 cycles later.
- st_req (0x2000, size 4, data 0xDEADBEEF), ld_req and ic_req all raised together -> order st, ld, ic; dn_wr=1 only for the first transaction.
- ld in BUSY, clr pulsed together with dn_done -> ld_done stays 0; dn_valid=0 next cycle; IDLE after RESP.
- st in BUSY, clr pulsed -> st_done still asserted on dn_done; dn_wdata=0xDEADBEEF unchanged throughout.
- With the macro defined and STARVE_LIMIT=2, ld_req continuously re-raised while ic_req is held -> ic granted on the third decision. Without the macro, ic is never granted while ld_req stays high.
- rdy low for 3 cycles mid-BUSY with dn_done pulsed during that window -> no done output; state and dn_* unchanged; rst mid-BUSY -> all outputs 0 the next cycle.
